lamp_safety_monitor: RTL and testbench
======================================

LAMP_SAFETY_MONITOR -- requirements
Module: lamp_safety_monitor

Interface
REQ-001 Parameter MIN_GREEN, default 8, meaning minimum tick_1s pulses a road SHALL stay GREEN before leaving GREEN.
REQ-002 Parameter FLASH_TICKS, default 1, meaning tick_1s pulses per flash half-period in FAULT.
REQ-003 clk  input  1  single clock; all flops SHALL be rising-edge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick_1s  input  1  one-cycle pulse, once per second, from the 1-second counter.
REQ-006 road1_in  input  3  road 1 lamp code from traffic state machine (001 RED, 010 YELLOW, 100 GREEN).
REQ-007 road2_in  input  3  road 2 lamp code, same encoding.
REQ-008 fault_clr  input  1  level; operator request to leave FAULT.
REQ-009 road1_lamp  output  3  registered lamp drive, road 1.
REQ-010 road2_lamp  output  3  registered lamp drive, road 2.
REQ-011 fault  output  1  registered; high while in FAULT.
REQ-012 fault_code  output  2  registered; 00 none, 01 invalid code, 10 conflict, 11 short green.

Function
REQ-013 Two states, PASS and FAULT; the block SHALL sit downstream of the traffic state machine and drive the lamps.
REQ-014 In PASS, road1_lamp/road2_lamp SHALL equal road1_in/road2_in sampled on the previous clk edge (latency 1 cycle).
REQ-015 Invalid: a road input not exactly one-hot (incl. 000) SHALL raise fault_code 01.
REQ-016 Conflict: both road inputs valid and neither equal to RED SHALL raise fault_code 10.
REQ-017 Per road, an 8-bit green counter SHALL clear when that road's input is not GREEN, increment on tick_1s while GREEN, and saturate at MIN_GREEN.
REQ-018 Short green: previous-cycle input GREEN, current input not GREEN, and that road's counter < MIN_GREEN SHALL raise fault_code 11.
REQ-019 Priority when several conditions hold in one cycle: 01 > 10 > 11.
REQ-020 A detected fault in PASS SHALL set fault=1 and fault_code on the next edge and move to FAULT; the violating inputs SHALL NOT reach the lamps.
REQ-021 In FAULT, both lamps SHALL show 001 when the internal flash bit is 1 and 000 when 0; flash SHALL be 1 on FAULT entry.
REQ-022 In FAULT, a flash tick counter SHALL count tick_1s; on reaching FLASH_TICKS it SHALL clear and toggle flash.
REQ-023 In FAULT, fault_code SHALL hold its entry value; new violations SHALL NOT overwrite it.
REQ-024 Exit: fault_clr=1 AND both inputs equal 001 in the same cycle SHALL move to PASS next edge, with fault=0, fault_code=00, lamps = sampled inputs, green counters cleared.
REQ-025 fault_clr in PASS SHALL have no effect; fault detection and fault_clr in the same cycle in PASS SHALL enter FAULT.
REQ-026 tick_1s coincident with FAULT entry SHALL NOT toggle flash; the flash tick counter SHALL start at 0.

Reset
REQ-027 rst=1 at a clk edge SHALL force state PASS, road1_lamp=001, road2_lamp=001, fault=0, fault_code=00, flash=1, all counters 0, previous-input registers 001.
REQ-028 rst SHALL override all other inputs, including mid-FAULT and mid-green.

Configuration
REQ-029 Macro LAMP_MON_STICKY_EN defined: fault_clr SHALL be ignored and FAULT SHALL exit only via rst.
REQ-030 Macro LAMP_MON_STICKY_EN undefined: exit per REQ-024.

Verification
REQ-031 Reset, then inputs 001/001 for 5 cycles -> lamps 001/001, fault=0, fault_code=00.
REQ-032 road1_in=100, road2_in=001 for 10 ticks, then road1_in=010 -> no fault; lamps follow inputs 1 cycle late.
REQ-033 road1_in=100 for 3 ticks then 010 -> fault=1, fault_code=11 next edge; lamps alternate 001/000 every tick_1s.
REQ-034 road1_in=100, road2_in=010 in one cycle -> fault_code=10; road1_in=011 with road2_in=100 in one cycle -> fault_code=01.
REQ-035 In FAULT: fault_clr=1 with road2_in=010 -> stays FAULT; fault_clr=1 with both 001 -> PASS, fault_code=00 next edge (with LAMP_MON_STICKY_EN -> stays FAULT until rst).
REQ-036 rst asserted mid-FAULT while flash=0 -> next edge lamps 001/001, fault=0.

Source files
------------

// File: rtl/lamp_mon_if.sv
// Lamp monitor bus: the traffic controller's lamp requests in, and the checked lamp drive and fault status out.
// handshake: none -- every signal is a level sampled on each rising clk, except tick_1s, which is a one-cycle strobe.
interface lamp_mon_if;
  logic       tick_1s;
  logic [2:0] road1_in;
  logic [2:0] road2_in;
  logic       fault_clr;
  logic [2:0] road1_lamp;
  logic [2:0] road2_lamp;
  logic       fault;
  logic [1:0] fault_code;
  logic       state_dbg;

  modport master (
    output tick_1s, road1_in, road2_in, fault_clr,
    input  road1_lamp, road2_lamp, fault, fault_code, state_dbg
  );

  modport slave (
    input  tick_1s, road1_in, road2_in, fault_clr,
    output road1_lamp, road2_lamp, fault, fault_code, state_dbg
  );
endinterface

// File: rtl/lamp_safety_monitor.sv
// Safety monitor between the traffic FSM and the lamps: passes valid codes through and latches a flashing-red FAULT.
// Optional macro LAMP_MON_STICKY_EN: FAULT can only be left through rst.
module lamp_safety_monitor #(
  parameter int MIN_GREEN   = 8,
  parameter int FLASH_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  lamp_mon_if.slave  bus
);

  typedef enum logic {S_PASS = 1'b0, S_FAULT = 1'b1} state_t;

  localparam logic [2:0] RED        = 3'b001;
  localparam logic [2:0] YELLOW     = 3'b010;
  localparam logic [2:0] GREEN      = 3'b100;
  localparam logic [7:0] MIN_G      = 8'(MIN_GREEN);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_TICKS - 1);

  state_t     state_q, state_d;
  logic [2:0] lamp1_q, lamp1_d, lamp2_q, lamp2_d;
  logic [2:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [7:0] green1_q, green1_d, green2_q, green2_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       flash_q, flash_d;
  logic       fault_q, fault_d;
  logic [1:0] code_q, code_d;

  logic       valid1, valid2, invalid, conflict, short1, short2;
  logic [1:0] det_code;
  logic       exit_req;

  function automatic logic is_lamp_code(input logic [2:0] v);
    return (v == RED) || (v == YELLOW) || (v == GREEN);
  endfunction

  // A short green is judged against the count accumulated before this cycle.
  always_comb begin
    valid1   = is_lamp_code(bus.road1_in);
    valid2   = is_lamp_code(bus.road2_in);
    invalid  = !valid1 || !valid2;
    conflict = valid1 && valid2 && (bus.road1_in != RED) && (bus.road2_in != RED);
    short1   = (prev1_q == GREEN) && (bus.road1_in != GREEN) && (green1_q < MIN_G);
    short2   = (prev2_q == GREEN) && (bus.road2_in != GREEN) && (green2_q < MIN_G);
    if (invalid)               det_code = 2'b01;
    else if (conflict)         det_code = 2'b10;
    else if (short1 || short2) det_code = 2'b11;
    else                       det_code = 2'b00;
  end

`ifdef LAMP_MON_STICKY_EN
  logic unused_fault_clr;
  assign unused_fault_clr = bus.fault_clr;
  assign exit_req = 1'b0;
`else
  assign exit_req = bus.fault_clr && (bus.road1_in == RED) && (bus.road2_in == RED);
`endif

  always_comb begin
    state_d  = state_q;
    lamp1_d  = lamp1_q;
    lamp2_d  = lamp2_q;
    fault_d  = fault_q;
    code_d   = code_q;
    flash_d  = flash_q;
    fcnt_d   = fcnt_q;
    prev1_d  = bus.road1_in;
    prev2_d  = bus.road2_in;
    green1_d = (bus.road1_in != GREEN) ? 8'd0 :
               (bus.tick_1s && (green1_q < MIN_G)) ? green1_q + 8'd1 : green1_q;
    green2_d = (bus.road2_in != GREEN) ? 8'd0 :
               (bus.tick_1s && (green2_q < MIN_G)) ? green2_q + 8'd1 : green2_q;

    case (state_q)
      S_PASS: begin
        if (det_code != 2'b00) begin
          // Violating codes never reach the lamps; entry shows red and ignores a coincident tick.
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = det_code;
          flash_d = 1'b1;
          fcnt_d  = 8'd0;
          lamp1_d = RED;
          lamp2_d = RED;
        end else begin
          lamp1_d = bus.road1_in;
          lamp2_d = bus.road2_in;
        end
      end
      S_FAULT: begin
        if (exit_req) begin
          state_d  = S_PASS;
          fault_d  = 1'b0;
          code_d   = 2'b00;
          flash_d  = 1'b1;
          fcnt_d   = 8'd0;
          green1_d = 8'd0;
          green2_d = 8'd0;
          lamp1_d  = bus.road1_in;
          lamp2_d  = bus.road2_in;
        end else begin
          if (bus.tick_1s) begin
            if (fcnt_q == FLASH_LAST) begin
              fcnt_d  = 8'd0;
              flash_d = !flash_q;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
          lamp1_d = flash_d ? RED : 3'b000;
          lamp2_d = flash_d ? RED : 3'b000;
        end
      end
      default: state_d = S_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_PASS;
      lamp1_q  <= RED;
      lamp2_q  <= RED;
      fault_q  <= 1'b0;
      code_q   <= 2'b00;
      flash_q  <= 1'b1;
      fcnt_q   <= 8'd0;
      green1_q <= 8'd0;
      green2_q <= 8'd0;
      prev1_q  <= RED;
      prev2_q  <= RED;
    end else begin
      state_q  <= state_d;
      lamp1_q  <= lamp1_d;
      lamp2_q  <= lamp2_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      flash_q  <= flash_d;
      fcnt_q   <= fcnt_d;
      green1_q <= green1_d;
      green2_q <= green2_d;
      prev1_q  <= prev1_d;
      prev2_q  <= prev2_d;
    end
  end

  assign bus.road1_lamp = lamp1_q;
  assign bus.road2_lamp = lamp2_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Directed bench for lamp_safety_monitor: pass-through latency, each fault class, flashing, exit and reset override.
module tb_lamp_safety_monitor;
  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

`ifdef LAMP_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  lamp_mon_if bus ();

  lamp_safety_monitor #(.MIN_GREEN(8), .FLASH_TICKS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running exp done");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic give_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1s = 1'b1;
      step();
      bus.tick_1s = 1'b0;
      step();
    end
  endtask

  task automatic drive(input logic [2:0] r1, input logic [2:0] r2);
    bus.road1_in = r1;
    bus.road2_in = r2;
  endtask

  // Returns to PASS with both roads red by whichever route the build allows.
  task automatic recover();
    drive(3'b001, 3'b001);
    if (STICKY) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
    end else begin
      bus.fault_clr = 1'b1;
      step();
      bus.fault_clr = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b001, 3'b001);
    step();
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code, bus.state_dbg} !== 10'b001_001_0_00_0) begin
      n_fail++;
      $display("FAIL reset_state: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code, bus.state_dbg}, 10'b001_001_0_00_0);
    end
    rst = 1'b0;
    repeat (5) step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code} !== 9'b001_001_0_00) begin
      n_fail++;
      $display("FAIL idle_red: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code}, 9'b001_001_0_00);
    end
  endtask

  task automatic test_green_pass();
    drive(3'b100, 3'b001);
    n_run++;
    if (bus.road1_lamp !== 3'b001) begin
      n_fail++;
      $display("FAIL latency_before: got %b exp %b", bus.road1_lamp, 3'b001);
    end
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp} !== 6'b100_001) begin
      n_fail++;
      $display("FAIL latency_after: got %b exp %b", {bus.road1_lamp, bus.road2_lamp}, 6'b100_001);
    end
    give_ticks(10);
    drive(3'b010, 3'b001);
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code} !== 9'b010_001_0_00) begin
      n_fail++;
      $display("FAIL long_green_yellow: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code}, 9'b010_001_0_00);
    end
    drive(3'b001, 3'b001);
    step();
    // Exactly MIN_GREEN ticks on road 2 is long enough.
    drive(3'b001, 3'b100);
    step();
    give_ticks(8);
    drive(3'b001, 3'b010);
    step();
    n_run++;
    if ({bus.road2_lamp, bus.fault, bus.fault_code} !== 6'b010_0_00) begin
      n_fail++;
      $display("FAIL green_exact_min: got %b exp %b", {bus.road2_lamp, bus.fault, bus.fault_code}, 6'b010_0_00);
    end
    drive(3'b001, 3'b001);
    step();
  endtask

  task automatic test_short_green();
    drive(3'b100, 3'b001);
    step();
    give_ticks(3);
    drive(3'b010, 3'b001);
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code, bus.state_dbg} !== 10'b001_001_1_11_1) begin
      n_fail++;
      $display("FAIL short_green_entry: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code, bus.state_dbg}, 10'b001_001_1_11_1);
    end
    bus.tick_1s = 1'b1;
    step();
    bus.tick_1s = 1'b0;
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL flash_off: got %b exp %b", {bus.road1_lamp, bus.road2_lamp}, 6'b000_000);
    end
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL flash_hold: got %b exp %b", {bus.road1_lamp, bus.road2_lamp}, 6'b000_000);
    end
    bus.tick_1s = 1'b1;
    drive(3'b100, 3'b010);
    step();
    bus.tick_1s = 1'b0;
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault_code} !== 8'b001_001_11) begin
      n_fail++;
      $display("FAIL flash_on_code_held: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault_code}, 8'b001_001_11);
    end
    bus.fault_clr = 1'b1;
    drive(3'b001, 3'b010);
    step();
    n_run++;
    if ({bus.fault, bus.fault_code} !== 3'b1_11) begin
      n_fail++;
      $display("FAIL clr_not_red: got %b exp %b", {bus.fault, bus.fault_code}, 3'b1_11);
    end
    drive(3'b001, 3'b001);
    step();
    bus.fault_clr = 1'b0;
    n_run++;
    if ({bus.fault, bus.fault_code} !== (STICKY ? 3'b1_11 : 3'b0_00)) begin
      n_fail++;
      $display("FAIL clr_exit: got %b exp %b", {bus.fault, bus.fault_code}, (STICKY ? 3'b1_11 : 3'b0_00));
    end
    if (STICKY) recover();
    // One tick short of MIN_GREEN still trips.
    drive(3'b100, 3'b001);
    step();
    give_ticks(7);
    drive(3'b010, 3'b001);
    step();
    n_run++;
    if ({bus.fault, bus.fault_code} !== 3'b1_11) begin
      n_fail++;
      $display("FAIL green_min_minus1: got %b exp %b", {bus.fault, bus.fault_code}, 3'b1_11);
    end
    recover();
  endtask

  task automatic test_conflict_invalid();
    drive(3'b100, 3'b010);
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code} !== 9'b001_001_1_10) begin
      n_fail++;
      $display("FAIL conflict: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code}, 9'b001_001_1_10);
    end
    recover();
    drive(3'b011, 3'b100);
    step();
    n_run++;
    if ({bus.fault, bus.fault_code} !== 3'b1_01) begin
      n_fail++;
      $display("FAIL invalid_011: got %b exp %b", {bus.fault, bus.fault_code}, 3'b1_01);
    end
    recover();
    drive(3'b001, 3'b000);
    step();
    n_run++;
    if ({bus.fault, bus.fault_code} !== 3'b1_01) begin
      n_fail++;
      $display("FAIL invalid_000: got %b exp %b", {bus.fault, bus.fault_code}, 3'b1_01);
    end
    recover();
    // Short green and conflict together: conflict wins.
    drive(3'b100, 3'b001);
    step();
    give_ticks(2);
    drive(3'b010, 3'b100);
    step();
    n_run++;
    if ({bus.fault, bus.fault_code} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL prio_conflict_short: got %b exp %b", {bus.fault, bus.fault_code}, 3'b1_10);
    end
    recover();
  endtask

  task automatic test_clr_in_pass();
    bus.fault_clr = 1'b1;
    drive(3'b100, 3'b001);
    step();
    n_run++;
    if ({bus.road1_lamp, bus.fault, bus.state_dbg} !== 5'b100_0_0) begin
      n_fail++;
      $display("FAIL clr_in_pass: got %b exp %b", {bus.road1_lamp, bus.fault, bus.state_dbg}, 5'b100_0_0);
    end
    drive(3'b100, 3'b010);
    step();
    n_run++;
    if ({bus.fault, bus.fault_code} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL clr_with_detect: got %b exp %b", {bus.fault, bus.fault_code}, 3'b1_10);
    end
    bus.fault_clr = 1'b0;
    recover();
  endtask

  task automatic test_tick_on_entry();
    bus.tick_1s = 1'b1;
    drive(3'b100, 3'b010);
    step();
    bus.tick_1s = 1'b0;
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault} !== 7'b001_001_1) begin
      n_fail++;
      $display("FAIL tick_on_entry: got %b exp %b", {bus.road1_lamp, bus.road2_lamp, bus.fault}, 7'b001_001_1);
    end
    give_ticks(1);
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL first_toggle: got %b exp %b", {bus.road1_lamp, bus.road2_lamp}, 6'b000_000);
    end
  endtask

  task automatic test_reset_mid_fault();
    // Entered from test_tick_on_entry with flash currently off.
    rst = 1'b1;
    drive(3'b100, 3'b010);
    bus.fault_clr = 1'b0;
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code, bus.state_dbg} !== 10'b001_001_0_00_0) begin
      n_fail++;
      $display("FAIL reset_mid_fault: got %b exp %b",
               {bus.road1_lamp, bus.road2_lamp, bus.fault, bus.fault_code, bus.state_dbg}, 10'b001_001_0_00_0);
    end
    drive(3'b001, 3'b001);
    step();
    rst = 1'b0;
    step();
    n_run++;
    if ({bus.road1_lamp, bus.road2_lamp, bus.fault} !== 7'b001_001_0) begin
      n_fail++;
      $display("FAIL after_reset_release: got %b exp %b", {bus.road1_lamp, bus.road2_lamp, bus.fault}, 7'b001_001_0);
    end
  endtask

  initial begin
    n_run         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.tick_1s   = 1'b0;
    bus.fault_clr = 1'b0;
    drive(3'b001, 3'b001);
    test_reset();
    test_green_pass();
    test_short_green();
    test_conflict_invalid();
    test_clr_in_pass();
    test_tick_on_entry();
    test_reset_mid_fault();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
